// File: rtl/led_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : led_status_monitor
// Purpose  : Board-status LED driver. Each raw status input is synchronised,
//            glitch-filtered and tracked through a per-channel state machine
//            that remembers loss-of-lock; every channel drives one LED with a
//            distinct pattern per state. A free-running counter supplies the
//            blink timebase and a heartbeat LED.
// Ports    : clk           - single clock for all logic
//            rst_n         - asynchronous active-low reset
//            status_in     - raw status levels (async to clk), 1 = good
//            fault_clr     - pulse clearing sticky fault history
//            status_good   - filtered status levels
//            fault_flags   - 1 while a channel is LOST or RECOVERED
//            ch_leds       - registered per-channel LED drive
//            led_heartbeat - MSB of the heartbeat counter
//            led_any_fault - registered OR of fault_flags
// Config   : LED_STATUS_STICKY_EN - when defined, enables the LOST/RECOVERED
//            fault history; otherwise each channel simply shows its filtered
//            level and fault outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module led_status_monitor #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 28,
  parameter int FILT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] status_in,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] status_good,
  output logic [NUM_CH-1:0] fault_flags,
  output logic [NUM_CH-1:0] ch_leds,
  output logic              led_heartbeat,
  output logic              led_any_fault
);

  localparam int                FCNT_W    = $clog2(FILT_LEN + 1);
  // The toggle happens on the FILT_LEN-th disagreeing edge, i.e. while the
  // counter still holds FILT_LEN-1.
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

  localparam logic [1:0] ST_DOWN      = 2'd0;
  localparam logic [1:0] ST_UP        = 2'd1;
  localparam logic [1:0] ST_LOST      = 2'd2;
  localparam logic [1:0] ST_RECOVERED = 2'd3;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] filt;
  logic [NUM_CH-1:0] filt_nxt;
  logic [NUM_CH-1:0] filt_d;
  logic [NUM_CH-1:0] led_nxt;
  logic [CNT_W-1:0]  hb_cnt;

  // Shared vector registers: synchroniser, filtered level, its one-cycle
  // delayed copy (edge detection and status_good), heartbeat and LEDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      filt_d  <= '0;
      hb_cnt  <= '0;
      ch_leds <= '0;
    end else begin
      sync1   <= status_in;
      sync2   <= sync1;
      filt    <= filt_nxt;
      filt_d  <= filt;
      hb_cnt  <= hb_cnt + CNT_W'(1);
      ch_leds <= led_nxt;
    end
  end

  // filt_d is aligned with the state registers, so status_good changes on
  // the same edge as the state it caused.
  assign status_good   = filt_d;
  assign led_heartbeat = hb_cnt[CNT_W-1];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [FCNT_W-1:0] cnt;
      logic              flip;

      assign flip        = (sync2[i] != filt[i]) && (cnt == FCNT_LAST);
      assign filt_nxt[i] = filt[i] ^ flip;

      // Counts consecutive disagreeing cycles; any agreement restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if ((sync2[i] == filt[i]) || flip) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + FCNT_W'(1);
        end
      end

`ifdef LED_STATUS_STICKY_EN
      logic       rise;
      logic       fall;
      logic [1:0] state;
      logic [1:0] state_nxt;

      assign rise = filt[i] & ~filt_d[i];
      assign fall = ~filt[i] & filt_d[i];

      // A fall always takes precedence over fault_clr; a rise together with
      // fault_clr in LOST lands directly in UP.
      always_comb begin
        state_nxt = state;
        case (state)
          ST_DOWN: begin
            if (rise) state_nxt = ST_UP;
          end
          ST_UP: begin
            if (fall) state_nxt = ST_LOST;
          end
          ST_LOST: begin
            if (rise)           state_nxt = fault_clr ? ST_UP : ST_RECOVERED;
            else if (fault_clr) state_nxt = ST_DOWN;
          end
          ST_RECOVERED: begin
            if (fall)           state_nxt = ST_LOST;
            else if (fault_clr) state_nxt = ST_UP;
          end
          default: state_nxt = ST_DOWN;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= ST_DOWN;
        end else begin
          state <= state_nxt;
        end
      end

      assign fault_flags[i] = (state == ST_LOST) || (state == ST_RECOVERED);
      assign led_nxt[i]     = (state == ST_UP)
                            | ((state == ST_LOST)      & hb_cnt[CNT_W-3])
                            | ((state == ST_RECOVERED) & hb_cnt[CNT_W-2]);
`else
      assign fault_flags[i] = 1'b0;
      assign led_nxt[i]     = filt_d[i];
`endif
    end
  endgenerate

`ifdef LED_STATUS_STICKY_EN
  logic any_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_fault_q <= 1'b0;
    end else begin
      any_fault_q <= |fault_flags;
    end
  end

  assign led_any_fault = any_fault_q;
`else
  logic unused_fault_clr;

  assign led_any_fault    = 1'b0;
  assign unused_fault_clr = fault_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_status_monitor
// Purpose  : Self-checking bench for led_status_monitor (NUM_CH=4, CNT_W=8,
//            FILT_LEN=4). An event-level model predicts all outputs every
//            cycle; directed steps add literal edge-exact expectations.
//            Works with or without LED_STATUS_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_monitor;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int HIST     = 4096;
`ifdef LED_STATUS_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int DOWN = 0, UP = 1, LOST = 2, RECOVERED = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] status_in = '0;
  logic              fault_clr = 1'b0;
  logic [NUM_CH-1:0] status_good;
  logic [NUM_CH-1:0] fault_flags;
  logic [NUM_CH-1:0] ch_leds;
  logic              led_heartbeat;
  logic              led_any_fault;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  led_status_monitor #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .status_in     (status_in),
    .fault_clr     (fault_clr),
    .status_good   (status_good),
    .fault_flags   (fault_flags),
    .ch_leds       (ch_leds),
    .led_heartbeat (led_heartbeat),
    .led_any_fault (led_any_fault)
  );

  // ---------------------------------------------------------------- model
  // e counts clock edges since reset; raw[e] is status_in seen at edge e.
  // The synchronised value used at edge k is raw[k-2]. The filtered level
  // flips at edge e when the last FILT_LEN synchronised samples all differ
  // from it and none of them precedes the previous flip.
  int                e;
  logic [NUM_CH-1:0] raw [HIST];
  logic [NUM_CH-1:0] m_filt, m_good, m_led;
  logic              m_any;
  int                m_st [NUM_CH];
  int                last_flip [NUM_CH];
  bit                m_rise, m_fall, m_all;
  logic              m_s2;

  function automatic logic led_of(input int st, input int hb);
    case (st)
      UP:        return 1'b1;
      LOST:      return ((hb >> (CNT_W - 3)) & 1) != 0;
      RECOVERED: return ((hb >> (CNT_W - 2)) & 1) != 0;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] exp_faults();
    logic [NUM_CH-1:0] f;
    f = '0;
    for (int c = 0; c < NUM_CH; c++)
      f[c] = STICKY && (m_st[c] == LOST || m_st[c] == RECOVERED);
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e      = 0;
      m_filt = '0;
      m_good = '0;
      m_led  = '0;
      m_any  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_st[c]      = DOWN;
        last_flip[c] = -1;
      end
    end else begin
      if (e >= HIST) begin
        $display("FAIL model_history: edge %0d exceeds limit %0d", e, HIST);
        $fatal(1);
      end
      raw[e] = status_in;
      // LEDs and the fault summary register the pre-edge state and counter.
      m_any = |exp_faults();
      for (int c = 0; c < NUM_CH; c++)
        m_led[c] = led_of(m_st[c], e % (1 << CNT_W));
      for (int c = 0; c < NUM_CH; c++) begin
        m_rise = m_filt[c] && !m_good[c];
        m_fall = !m_filt[c] && m_good[c];
        if (!STICKY) begin
          if (m_rise)      m_st[c] = UP;
          else if (m_fall) m_st[c] = DOWN;
        end else begin
          case (m_st[c])
            DOWN:      if (m_rise) m_st[c] = UP;
            UP:        if (m_fall) m_st[c] = LOST;
            LOST:      if (m_rise) m_st[c] = fault_clr ? UP : RECOVERED;
                       else if (fault_clr) m_st[c] = DOWN;
            RECOVERED: if (m_fall) m_st[c] = LOST;
                       else if (fault_clr) m_st[c] = UP;
            default:   m_st[c] = DOWN;
          endcase
        end
      end
      m_good = m_filt;
      for (int c = 0; c < NUM_CH; c++) begin
        if (e - last_flip[c] >= FILT_LEN) begin
          m_all = 1'b1;
          for (int k = e - FILT_LEN + 1; k <= e; k++) begin
            m_s2 = (k >= 2) ? raw[k-2][c] : 1'b0;
            if (m_s2 == m_filt[c]) m_all = 1'b0;
          end
          if (m_all) begin
            m_filt[c]    = ~m_filt[c];
            last_flip[c] = e;
          end
        end
      end
      e = e + 1;
    end
  end

  // ------------------------------------------------------------ checking
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("status_good",   32'(status_good),   32'(m_good));
      cmp("fault_flags",   32'(fault_flags),   32'(exp_faults()));
      cmp("ch_leds",       32'(ch_leds),       32'(m_led));
      cmp("led_heartbeat", 32'(led_heartbeat), 32'((e % (1 << CNT_W)) >= (1 << (CNT_W - 1))));
      cmp("led_any_fault", 32'(led_any_fault), 32'(m_any));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic get_sig(input int sel);
    return (sel == 0) ? led_heartbeat : ch_leds[0];
  endfunction

  // Measures cycles between two successive toggles of the selected signal.
  task automatic chk_period(input int sel, input int exp, input string nm);
    logic v0;
    int   n;
    int   limit;
    limit = 4 * exp + 10;
    v0 = get_sig(sel);
    n  = 0;
    while (get_sig(sel) == v0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    v0 = get_sig(sel);
    n  = 0;
    while (get_sig(sel) == v0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    cmp(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    rst_n     = 1'b0;
    status_in = '0;
    fault_clr = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    cmp("rst_ch_leds",   32'(ch_leds),       0);
    cmp("rst_heartbeat", 32'(led_heartbeat), 0);

    // 1: reset release, everything idle, heartbeat half-period 128
    rst_n = 1'b1;
    cyc(20);
    cmp("t1_status_good", 32'(status_good), 0);
    cmp("t1_fault_flags", 32'(fault_flags), 0);
    chk_period(0, 128, "t1_hb_half_period");

    // 2: channel 0 rises; status at edge 6, LED at edge 7
    status_in[0] = 1'b1;
    cyc(6);
    cmp("t2_good0_edge5", 32'(status_good[0]), 0);
    cyc(1);
    cmp("t2_good0_edge6", 32'(status_good[0]), 1);
    cmp("t2_led0_edge6",  32'(ch_leds[0]),     0);
    cyc(1);
    cmp("t2_led0_edge7",  32'(ch_leds[0]),     1);
    status_in[1] = 1'b1;
    cyc(3);
    status_in[1] = 1'b0;
    cyc(12);
    cmp("t2_pulse_good1", 32'(status_good[1]), 0);
    cmp("t2_pulse_led1",  32'(ch_leds[1]),     0);

    // 3: channel 0 lost, then restored
    status_in[0] = 1'b0;
    cyc(6);
    cmp("t3_flag0_edge5", 32'(fault_flags[0]), 0);
    cyc(1);
    cmp("t3_flag0_edge6", 32'(fault_flags[0]), 32'(STICKY));
    cyc(1);
    cmp("t3_any_edge7",   32'(led_any_fault),  32'(STICKY));
    if (STICKY) chk_period(1, 32, "t3_lost_blink");
    else        cmp("t3_led0_off", 32'(ch_leds[0]), 0);
    status_in[0] = 1'b1;
    cyc(8);
    cmp("t3_flag0_recov", 32'(fault_flags[0]), 32'(STICKY));
    if (STICKY) chk_period(1, 64, "t3_recov_blink");
    else        cmp("t3_led0_on", 32'(ch_leds[0]), 1);

    // 4: fault_clr from RECOVERED, then from LOST
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cmp("t4_flag0_clr",  32'(fault_flags[0]), 0);
    cyc(1);
    cmp("t4_led0_up",    32'(ch_leds[0]),     1);
    cmp("t4_any_clr",    32'(led_any_fault),  0);
    cyc(40);
    cmp("t4_led0_steady", 32'(ch_leds[0]),    1);
    status_in[0] = 1'b0;
    cyc(8);
    cmp("t4_flag0_lost", 32'(fault_flags[0]), 32'(STICKY));
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cmp("t4_flag0_down", 32'(fault_flags[0]), 0);
    cyc(1);
    cmp("t4_led0_down",  32'(ch_leds[0]),     0);

    // 5: simultaneous fall and fault_clr on channel 2, then async reset
    status_in[2] = 1'b1;
    status_in[3] = 1'b1;
    cyc(8);
    cmp("t5_led2_up", 32'(ch_leds[2]), 1);
    status_in[2] = 1'b0;
    cyc(6);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cmp("t5_flag2_fallwins", 32'(fault_flags[2]), 32'(STICKY));
    cmp("t5_good2",          32'(status_good[2]), 0);
    cyc(20);
    cmp("t5_led3_pre_rst",   32'(ch_leds[3]),     1);
    #2 rst_n = 1'b0;
    #1;
    cmp("t5_rst_good",   32'(status_good),   0);
    cmp("t5_rst_flags",  32'(fault_flags),   0);
    cmp("t5_rst_leds",   32'(ch_leds),       0);
    cmp("t5_rst_any",    32'(led_any_fault), 0);
    cmp("t5_rst_hb",     32'(led_heartbeat), 0);
    cyc(3);
    rst_n     = 1'b1;
    status_in = '0;
    cyc(10);
    cmp("t5_post_rst_flags", 32'(fault_flags), 0);

    // 6: channel 3 toggling, 7-edge LED latency; fault_clr in idle state
    status_in[3] = 1'b1;
    cyc(7);
    cmp("t6_led3_edge6", 32'(ch_leds[3]), 0);
    cyc(1);
    cmp("t6_led3_edge7", 32'(ch_leds[3]), 1);
    status_in[3] = 1'b0;
    cyc(7);
    cmp("t6_led3_hold",  32'(ch_leds[3]), 1);
    cyc(1);
    if (!STICKY) cmp("t6_led3_off", 32'(ch_leds[3]), 0);
    cmp("t6_flag3", 32'(fault_flags[3]), 32'(STICKY));
    fault_clr = 1'b1;
    cyc(3);
    fault_clr = 1'b0;
    cyc(2);
    cmp("t6_flags_after_clr", 32'(fault_flags), 0);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
